// File: rtl/mpt_plb.sv
// rtl/mpt_plb.sv - fully-associative MPT permission lookaside buffer
// Optional hit/miss statistics counters are built when MPT_PLB_STATS_EN is defined.
module mpt_plb #(
  parameter int NUM_ENTRIES      = 8,
  parameter int XLEN             = 64,
  parameter int SDID_LEN         = 6,
  parameter int RANGE_OFFSET_LEN = 16
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        lookup_valid_i,
  output logic                                        lookup_ready_o,
  input  logic [SDID_LEN-1:0]                         lookup_sdid_i,
  input  logic [XLEN-1:0]                             lookup_spa_i,
  input  logic [1:0]                                  lookup_access_i,
  output logic                                        resp_valid_o,
  output logic                                        resp_hit_o,
  output logic [2:0]                                  resp_perms_o,
  output logic                                        resp_allow_o,
  input  logic                                        fill_valid_i,
  input  logic [SDID_LEN-1:0]                         fill_sdid_i,
  input  logic [XLEN-1:0]                             fill_spa_i,
  input  logic [3*(1<<(RANGE_OFFSET_LEN-12))-1:0]     fill_perms_i,
`ifdef MPT_PLB_STATS_EN
  output logic [31:0]                                 hit_count_o,
  output logic [31:0]                                 miss_count_o,
`endif
  input  logic                                        flush_i,
  input  logic                                        flush_sdid_only_i,
  input  logic [SDID_LEN-1:0]                         flush_sdid_i
);

  localparam int PAGES  = 1 << (RANGE_OFFSET_LEN - 12);
  localparam int PIDX_W = RANGE_OFFSET_LEN - 12;
  localparam int TAG_W  = XLEN - RANGE_OFFSET_LEN;
  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int PW     = 3 * PAGES;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [SDID_LEN-1:0]    sdid_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag_q   [NUM_ENTRIES];
  logic [PW-1:0]          perms_q [NUM_ENTRIES];
  logic [IDX_W-1:0]       victim_q;

  logic       resp_valid_q, resp_hit_q, resp_allow_q;
  logic [2:0] resp_perms_q;

  logic [TAG_W-1:0]  lk_tag, fl_tag;
  logic [PIDX_W-1:0] lk_pidx;
  logic [PIDX_W+1:0] lk_base;
  logic              lk_accept, lk_hit, lk_allow, perm_legal;
  logic [2:0]        lk_perms;
  logic              fill_hit, inv_found, fill_en;
  logic [IDX_W-1:0]  fill_idx, inv_idx, fill_tgt;
  logic              unused_bits;

  assign lk_tag      = lookup_spa_i[XLEN-1:RANGE_OFFSET_LEN];
  assign lk_pidx     = lookup_spa_i[RANGE_OFFSET_LEN-1:12];
  assign lk_base     = {1'b0, lk_pidx, 1'b0} + {2'b00, lk_pidx};
  assign fl_tag      = fill_spa_i[XLEN-1:RANGE_OFFSET_LEN];
  assign unused_bits = ^{lookup_spa_i[11:0], fill_spa_i[11:0]};

  assign lookup_ready_o = !flush_i && !fill_valid_i;
  assign lk_accept      = lookup_valid_i && lookup_ready_o;
  assign fill_en        = fill_valid_i && !flush_i;

  always_comb begin
    lk_hit   = 1'b0;
    lk_perms = 3'b000;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && sdid_q[i] == lookup_sdid_i && tag_q[i] == lk_tag) begin
        lk_hit   = 1'b1;
        lk_perms = perms_q[i][lk_base +: 3];
      end
    end
  end

  // Reserved encodings (000, 010, 110) deny every access type.
  always_comb begin
    perm_legal = 1'b0;
    case (lk_perms)
      3'b001, 3'b011, 3'b100, 3'b101, 3'b111: perm_legal = 1'b1;
      default:                                perm_legal = 1'b0;
    endcase
    case (lookup_access_i)
      2'b01:   lk_allow = perm_legal & lk_perms[0];
      2'b10:   lk_allow = perm_legal & lk_perms[1];
      2'b11:   lk_allow = perm_legal & lk_perms[2];
      default: lk_allow = 1'b0;
    endcase
  end

  always_comb begin
    fill_hit  = 1'b0;
    fill_idx  = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!fill_hit && valid_q[i] && sdid_q[i] == fill_sdid_i && tag_q[i] == fl_tag) begin
        fill_hit = 1'b1;
        fill_idx = IDX_W'(i);
      end
      if (!inv_found && !valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
    fill_tgt = fill_hit ? fill_idx : (inv_found ? inv_idx : victim_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && fill_en) begin
      sdid_q[fill_tgt]  <= fill_sdid_i;
      tag_q[fill_tgt]   <= fl_tag;
      perms_q[fill_tgt] <= fill_perms_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_perms_q <= 3'b000;
      resp_allow_q <= 1'b0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (!flush_sdid_only_i || sdid_q[i] == flush_sdid_i) begin
            valid_q[i] <= 1'b0;
          end
        end
      end else if (fill_valid_i) begin
        valid_q[fill_tgt] <= 1'b1;
        if (!fill_hit && !inv_found) begin
          victim_q <= victim_q + 1'b1;
        end
      end
      resp_valid_q <= lk_accept;
      resp_hit_q   <= lk_accept & lk_hit;
      resp_perms_q <= lk_accept ? lk_perms : 3'b000;
      resp_allow_q <= lk_accept & lk_allow;
    end
  end

  // Gate with reset so a response due in the reset cycle never escapes.
  assign resp_valid_o = resp_valid_q & ~rst_i;
  assign resp_hit_o   = resp_hit_q & ~rst_i;
  assign resp_perms_o = rst_i ? 3'b000 : resp_perms_q;
  assign resp_allow_o = resp_allow_q & ~rst_i;

`ifdef MPT_PLB_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lk_accept) begin
      if (lk_hit && hit_cnt_q != 32'hFFFF_FFFF) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (!lk_hit && miss_cnt_q != 32'hFFFF_FFFF) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mpt_plb.sv
// tb/tb_mpt_plb.sv - directed self-checking bench for mpt_plb
// Statistics checks are compiled when MPT_PLB_STATS_EN is defined.
module tb_mpt_plb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lookup_valid_i;
  logic        lookup_ready_o;
  logic [5:0]  lookup_sdid_i;
  logic [63:0] lookup_spa_i;
  logic [1:0]  lookup_access_i;
  logic        resp_valid_o, resp_hit_o, resp_allow_o;
  logic [2:0]  resp_perms_o;
  logic        fill_valid_i;
  logic [5:0]  fill_sdid_i;
  logic [63:0] fill_spa_i;
  logic [47:0] fill_perms_i;
  logic        flush_i, flush_sdid_only_i;
  logic [5:0]  flush_sdid_i;
`ifdef MPT_PLB_STATS_EN
  logic [31:0] hit_count_o, miss_count_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] r_resp;

  always #5 clk_i = ~clk_i;

  mpt_plb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_sdid_i(lookup_sdid_i), .lookup_spa_i(lookup_spa_i),
    .lookup_access_i(lookup_access_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o),
    .resp_perms_o(resp_perms_o), .resp_allow_o(resp_allow_o),
    .fill_valid_i(fill_valid_i), .fill_sdid_i(fill_sdid_i),
    .fill_spa_i(fill_spa_i), .fill_perms_i(fill_perms_i),
`ifdef MPT_PLB_STATS_EN
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o),
`endif
    .flush_i(flush_i), .flush_sdid_only_i(flush_sdid_only_i),
    .flush_sdid_i(flush_sdid_i)
  );

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic do_fill(input logic [5:0] sdid, input logic [63:0] spa, input logic [47:0] perms);
    @(negedge clk_i);
    fill_valid_i = 1'b1;
    fill_sdid_i  = sdid;
    fill_spa_i   = spa;
    fill_perms_i = perms;
    @(negedge clk_i);
    fill_valid_i = 1'b0;
  endtask

  task automatic do_flush(input logic only, input logic [5:0] sdid);
    @(negedge clk_i);
    flush_i           = 1'b1;
    flush_sdid_only_i = only;
    flush_sdid_i      = sdid;
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  // Leaves {valid, hit, perms, allow} of the response in r_resp.
  task automatic do_lookup(input logic [5:0] sdid, input logic [63:0] spa, input logic [1:0] acc);
    @(negedge clk_i);
    lookup_valid_i  = 1'b1;
    lookup_sdid_i   = sdid;
    lookup_spa_i    = spa;
    lookup_access_i = acc;
    @(negedge clk_i);
    lookup_valid_i = 1'b0;
    r_resp = {resp_valid_o, resp_hit_o, resp_perms_o, resp_allow_o};
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({resp_valid_o, resp_hit_o, resp_perms_o, resp_allow_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_resp: got %b expected 000000", {resp_valid_o, resp_hit_o, resp_perms_o, resp_allow_o});
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (lookup_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", lookup_ready_o);
    end
    do_lookup(6'd3, 64'h0001_2ABC, 2'b01);
    checks++;
    if (r_resp !== 6'b10_000_0) begin
      errors++;
      $display("FAIL reset_empty_lookup: got %b expected 100000", r_resp);
    end
  endtask

  task automatic test_perms();
    logic [47:0] p;
    logic [63:0] spa_q [10];
    logic [5:0]  sd_q  [10];
    logic [1:0]  acc_q [10];
    logic [5:0]  exp_q [10];
    p = '0;
    p[8:6]   = 3'b011;
    p[14:12] = 3'b010;
    p[17:15] = 3'b100;
    p[20:18] = 3'b101;
    do_fill(6'd3, 64'h0001_2000, p);
    spa_q = '{64'h0001_2ABC, 64'h0001_2ABC, 64'h0001_2ABC, 64'h0001_2ABC, 64'h0001_2ABC,
              64'h0001_3000, 64'h0001_4FFF, 64'h0001_5010, 64'h0001_6000, 64'h0002_2ABC};
    sd_q  = '{6'd3, 6'd3, 6'd3, 6'd3, 6'd4, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3};
    acc_q = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
    exp_q = '{6'b11_011_1, 6'b11_011_1, 6'b11_011_0, 6'b11_011_0, 6'b10_000_0,
              6'b11_000_0, 6'b11_010_0, 6'b11_100_1, 6'b11_101_0, 6'b10_000_0};
    for (int i = 0; i < 10; i++) begin
      do_lookup(sd_q[i], spa_q[i], acc_q[i]);
      checks++;
      if (r_resp !== exp_q[i]) begin
        errors++;
        $display("FAIL perms_vec%0d: got %b expected %b", i, r_resp, exp_q[i]);
      end
    end
  endtask

  task automatic test_eviction();
    do_reset();
    for (int t = 0; t <= 8; t++) do_fill(6'd1, 64'(t) << 16, 48'h1);
    for (int t = 0; t <= 8; t++) begin
      do_lookup(6'd1, 64'(t) << 16, 2'b01);
      checks++;
      if (r_resp !== ((t == 0) ? 6'b10_000_0 : 6'b11_001_1)) begin
        errors++;
        $display("FAIL evict_tag%0d: got %b expected %b", t, r_resp, (t == 0) ? 6'b10_000_0 : 6'b11_001_1);
      end
    end
    do_fill(6'd1, 64'h0009_0000, 48'h1);
    do_lookup(6'd1, 64'h0001_0000, 2'b01);
    checks++;
    if (r_resp !== 6'b10_000_0) begin
      errors++;
      $display("FAIL evict_ptr1: got %b expected 100000", r_resp);
    end
    do_fill(6'd1, 64'h0005_0000, 48'h7);
    do_lookup(6'd1, 64'h0005_0000, 2'b11);
    checks++;
    if (r_resp !== 6'b11_111_1) begin
      errors++;
      $display("FAIL overwrite_perms: got %b expected 111111", r_resp);
    end
    do_fill(6'd1, 64'h000A_0000, 48'h1);
    do_lookup(6'd1, 64'h0002_0000, 2'b01);
    checks++;
    if (r_resp !== 6'b10_000_0) begin
      errors++;
      $display("FAIL overwrite_keeps_ptr: got %b expected 100000", r_resp);
    end
    do_lookup(6'd1, 64'h0003_0000, 2'b01);
    checks++;
    if (r_resp !== 6'b11_001_1) begin
      errors++;
      $display("FAIL overwrite_no_dup: got %b expected 110011", r_resp);
    end
  endtask

  task automatic test_flush();
    do_reset();
    do_fill(6'd1, 64'h0010_0000, 48'h1);
    do_fill(6'd2, 64'h0010_0000, 48'h1);
    do_flush(1'b1, 6'd1);
    do_lookup(6'd1, 64'h0010_0000, 2'b01);
    checks++;
    if (r_resp !== 6'b10_000_0) begin
      errors++;
      $display("FAIL flush_sdid1: got %b expected 100000", r_resp);
    end
    do_lookup(6'd2, 64'h0010_0000, 2'b01);
    checks++;
    if (r_resp !== 6'b11_001_1) begin
      errors++;
      $display("FAIL flush_keeps_sdid2: got %b expected 110011", r_resp);
    end
    @(negedge clk_i);
    flush_i = 1'b1; flush_sdid_only_i = 1'b1; flush_sdid_i = 6'd5;
    fill_valid_i = 1'b1; fill_sdid_i = 6'd1; fill_spa_i = 64'h0020_0000; fill_perms_i = 48'h1;
    #1;
    checks++;
    if (lookup_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b expected 0", lookup_ready_o);
    end
    @(negedge clk_i);
    flush_i = 1'b0; fill_valid_i = 1'b0;
    do_lookup(6'd1, 64'h0020_0000, 2'b01);
    checks++;
    if (r_resp !== 6'b10_000_0) begin
      errors++;
      $display("FAIL fill_dropped: got %b expected 100000", r_resp);
    end
    do_flush(1'b0, 6'd0);
    do_lookup(6'd2, 64'h0010_0000, 2'b01);
    checks++;
    if (r_resp !== 6'b10_000_0) begin
      errors++;
      $display("FAIL flush_all: got %b expected 100000", r_resp);
    end
  endtask

  task automatic test_fill_collision();
    @(negedge clk_i);
    lookup_valid_i = 1'b1; lookup_sdid_i = 6'd7; lookup_spa_i = 64'h0030_1000; lookup_access_i = 2'b01;
    fill_valid_i = 1'b1; fill_sdid_i = 6'd7; fill_spa_i = 64'h0030_0000; fill_perms_i = 48'h8;
    #1;
    checks++;
    if (lookup_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL collide_ready: got %b expected 0", lookup_ready_o);
    end
    @(negedge clk_i);
    fill_valid_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL collide_no_resp: got %b expected 0", resp_valid_o);
    end
    @(negedge clk_i);
    lookup_valid_i = 1'b0;
    checks++;
    if ({resp_valid_o, resp_hit_o, resp_perms_o, resp_allow_o} !== 6'b11_001_1) begin
      errors++;
      $display("FAIL collide_retry: got %b expected 110011", {resp_valid_o, resp_hit_o, resp_perms_o, resp_allow_o});
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    lookup_valid_i = 1'b1; lookup_sdid_i = 6'd7; lookup_spa_i = 64'h0030_1000; lookup_access_i = 2'b01;
    @(negedge clk_i);
    lookup_sdid_i = 6'd8;
    checks++;
    if ({resp_valid_o, resp_hit_o} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_first: got %b expected 11", {resp_valid_o, resp_hit_o});
    end
    @(negedge clk_i);
    lookup_sdid_i = 6'd7;
    checks++;
    if ({resp_valid_o, resp_hit_o} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_second: got %b expected 10", {resp_valid_o, resp_hit_o});
    end
    @(negedge clk_i);
    lookup_valid_i = 1'b0;
    flush_i = 1'b1; flush_sdid_only_i = 1'b0;
    checks++;
    if ({resp_valid_o, resp_hit_o, resp_perms_o} !== 5'b11_001) begin
      errors++;
      $display("FAIL resp_vs_flush: got %b expected 11001", {resp_valid_o, resp_hit_o, resp_perms_o});
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL resp_one_cycle: got %b expected 0", resp_valid_o);
    end
  endtask

  task automatic test_reset_drop();
    do_fill(6'd9, 64'h0040_0000, 48'h1);
    @(negedge clk_i);
    lookup_valid_i = 1'b1; lookup_sdid_i = 6'd9; lookup_spa_i = 64'h0040_0000; lookup_access_i = 2'b01;
    @(negedge clk_i);
    lookup_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({resp_valid_o, resp_hit_o, resp_perms_o, resp_allow_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_drop: got %b expected 000000", {resp_valid_o, resp_hit_o, resp_perms_o, resp_allow_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    do_lookup(6'd9, 64'h0040_0000, 2'b01);
    checks++;
    if (r_resp !== 6'b10_000_0) begin
      errors++;
      $display("FAIL reset_clears_valid: got %b expected 100000", r_resp);
    end
  endtask

`ifdef MPT_PLB_STATS_EN
  task automatic test_stats();
    do_reset();
    do_fill(6'd1, 64'h0050_0000, 48'h1);
    for (int i = 0; i < 5; i++) do_lookup(6'd1, (i < 3) ? 64'h0050_0000 : 64'h0060_0000, 2'b01);
    checks++;
    if ({hit_count_o, miss_count_o} !== {32'd3, 32'd2}) begin
      errors++;
      $display("FAIL stats_count: got %0d/%0d expected 3/2", hit_count_o, miss_count_o);
    end
    @(negedge clk_i);
    dut.hit_cnt_q = 32'hFFFF_FFFF;
    do_lookup(6'd1, 64'h0050_0000, 2'b01);
    checks++;
    if (hit_count_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stats_saturate: got %h expected ffffffff", hit_count_o);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    lookup_valid_i = 1'b0; lookup_sdid_i = '0; lookup_spa_i = '0; lookup_access_i = '0;
    fill_valid_i = 1'b0; fill_sdid_i = '0; fill_spa_i = '0; fill_perms_i = '0;
    flush_i = 1'b0; flush_sdid_only_i = 1'b0; flush_sdid_i = '0;
    test_reset();
    test_perms();
    test_eviction();
    test_flush();
    test_fill_collision();
    test_back_to_back();
    test_reset_drop();
`ifdef MPT_PLB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpt_plb.md
MPT_PLB -- requirements
Module: mpt_plb

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, number of fully-associative entries; power of two, 2..64.
REQ-002 SHALL have parameter XLEN, default 64, physical address width.
REQ-003 SHALL have parameter SDID_LEN, default 6, supervisor domain identifier width.
REQ-004 SHALL have parameter RANGE_OFFSET_LEN, default 16, log2 of range bytes per entry; PAGES = 2^(RANGE_OFFSET_LEN-12), 4 KiB pages.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-006 lookup_valid_i  in  1  lookup request valid.
REQ-007 lookup_ready_o  out  1  lookup accepted this cycle when high with lookup_valid_i.
REQ-008 lookup_sdid_i  in  SDID_LEN  requesting domain.
REQ-009 lookup_spa_i  in  XLEN  supervisor physical address.
REQ-010 lookup_access_i  in  2  access type, 00 none, 01 read, 10 write, 11 exec.
REQ-011 resp_valid_o  out  1  one-cycle response strobe.
REQ-012 resp_hit_o  out  1  entry matched.
REQ-013 resp_perms_o  out  3  page permission field, {X,W,R}.
REQ-014 resp_allow_o  out  1  access permitted.
REQ-015 fill_valid_i  in  1  install entry from walker.
REQ-016 fill_sdid_i  in  SDID_LEN; fill_spa_i  in  XLEN; fill_perms_i  in  3*PAGES  leaf permissions, page p at bits [3p+2:3p].
REQ-017 flush_i  in  1  flush request; flush_sdid_only_i  in  1  restrict flush to flush_sdid_i; flush_sdid_i  in  SDID_LEN.

Function
REQ-018 Tag SHALL be spa[XLEN-1:RANGE_OFFSET_LEN]; page index SHALL be spa[RANGE_OFFSET_LEN-1:12]; bits [11:0] ignored.
REQ-019 lookup_ready_o SHALL equal !flush_i && !fill_valid_i; priority flush > fill > lookup.
REQ-020 Accepted lookup SHALL produce resp_valid_o high exactly one cycle later, for one cycle; back-to-back lookups give back-to-back responses.
REQ-021 Hit SHALL mean entry valid, SDID equal and tag equal; at most one entry matches.
REQ-022 On hit resp_perms_o SHALL be the indexed page field; on miss resp_hit_o=0, resp_perms_o=000, resp_allow_o=0.
REQ-023 resp_allow_o SHALL be 1 only if perms is one of 001,011,100,101,111 and its R (read), W (write) or X (exec) bit is set; access none always gives 0; reserved encodings 000,010,110 deny all.
REQ-024 Fill whose SDID+tag matches a valid entry SHALL overwrite that entry in place.
REQ-025 Otherwise fill SHALL use the lowest-index invalid entry; if none, the entry at the round-robin victim pointer, then pointer increments modulo NUM_ENTRIES (wraps NUM_ENTRIES-1 to 0).
REQ-026 Fill SHALL be visible to lookups accepted from the next cycle.
REQ-027 flush_i with flush_sdid_only_i=0 SHALL clear all valid bits in one cycle; with 1, only entries whose SDID equals flush_sdid_i; pointer unchanged.
REQ-028 Fill asserted with flush_i SHALL be dropped.
REQ-029 Response of a lookup accepted in cycle N SHALL not be altered by a flush or fill in cycle N+1.

Reset
REQ-030 rst_i SHALL clear all valid bits, victim pointer to 0, resp_valid_o, resp_hit_o, resp_perms_o, resp_allow_o to 0.
REQ-031 rst_i SHALL dominate every input; a lookup accepted the cycle before reset yields no response.

Configuration
REQ-032 Macro MPT_PLB_STATS_EN defined: ports hit_count_o and miss_count_o (out, 32) SHALL count responses with hit=1/0, saturate at 32'hFFFFFFFF, reset to 0, unaffected by flush.
REQ-033 Macro undefined: these ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-034 Fill sdid 3, spa 0x0001_2000, page 2 perms 011; lookup sdid 3, spa 0x0001_2ABC, write -> next cycle hit=1, perms=011, allow=1.
REQ-035 Same entry, lookup exec -> hit=1, allow=0; lookup sdid 4 same spa -> hit=0, perms=000.
REQ-036 NUM_ENTRIES=8: fill 9 distinct tags, sdid 1 -> tag 0 evicted (miss), tags 1..8 hit, pointer=1.
REQ-037 Entries sdid 1 and 2; flush_i, flush_sdid_only_i=1, flush_sdid_i=1 -> sdid 1 misses, sdid 2 hits; full flush -> both miss.
REQ-038 lookup_valid_i with fill_valid_i same cycle -> lookup_ready_o=0; lookup retried next cycle hits new entry.
REQ-039 MPT_PLB_STATS_EN: 3 hits, 2 misses -> hit_count_o=3, miss_count_o=2; preload 32'hFFFFFFFF, hit -> stays FFFFFFFF.
